// File: rtl/LDPC_pkg.sv
// Shared LDPC encoder constants.
package LDPC_pkg;
    // Largest lifting size supported by BG1/BG2.
    localparam int MAX_ZC = 384;
endpackage

// File: rtl/ldpc_parity_select_rotate_if.sv
// Bus between the parity-block generator, the select/rotate stage and the
// codeword accumulator.
//
// Handshake: a beat moves on a rising clk edge where valid && ready are both
// high. A source holds valid and its payload steady until the beat moves; a
// sink may raise or drop ready freely. in_ready never depends on in_valid.
interface ldpc_parity_select_rotate_if
    import LDPC_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int NUM_LANES  = 23
);
    localparam int SEL_W   = $clog2(NUM_INPUTS);
    localparam int SHIFT_W = $clog2(MAX_ZC);

    logic                                   in_valid;
    logic                                   in_ready;
    logic [SHIFT_W:0]                       zc;
    logic [NUM_INPUTS-1:0][MAX_ZC-1:0]      parity_blocks;
    logic [NUM_LANES-1:0][SEL_W-1:0]        select_lines;
    logic [NUM_LANES-1:0][SHIFT_W-1:0]      shift_amounts;
    logic [NUM_LANES-1:0]                   lane_enable;
    logic                                   out_valid;
    logic                                   out_ready;
    logic [NUM_LANES-1:0][MAX_ZC-1:0]       out_blocks;

    modport master (
        output in_valid, zc, parity_blocks, select_lines, shift_amounts,
               lane_enable, out_ready,
        input  in_ready, out_valid, out_blocks
    );

    modport slave (
        input  in_valid, zc, parity_blocks, select_lines, shift_amounts,
               lane_enable, out_ready,
        output in_ready, out_valid, out_blocks
    );
endinterface

// File: rtl/ldpc_parity_select_rotate.sv
// Per-lane parity block select (stage 1) and cyclic rotation within the
// active lifting size zc (stage 2), with valid/ready backpressure and a
// sticky error flag.
module ldpc_parity_select_rotate
    import LDPC_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int NUM_LANES  = 23
) (
    input  logic                         clk,
    input  logic                         rst,
    ldpc_parity_select_rotate_if.slave   bus,
    input  logic                         err_clear,
    output logic                         err_flag
);
    localparam int SEL_W   = $clog2(NUM_INPUTS);
    localparam int SHIFT_W = $clog2(MAX_ZC);
    localparam int ZC_W    = SHIFT_W + 1;

    // Stage 1 registers
    logic                                s1_valid_q, s1_valid_d;
    logic [NUM_LANES-1:0][MAX_ZC-1:0]    s1_blk_q, s1_blk_d;
    logic [NUM_LANES-1:0][SHIFT_W-1:0]   s1_shift_q, s1_shift_d;
    logic [ZC_W-1:0]                     s1_zc_q, s1_zc_d;
    logic [NUM_LANES-1:0]                s1_lane_err_q, s1_lane_err_d;
    logic [NUM_LANES-1:0]                s1_kill_q, s1_kill_d;
    logic                                s1_zc_err_q, s1_zc_err_d;
    // Stage 2 registers
    logic                                s2_valid_q, s2_valid_d;
    logic [NUM_LANES-1:0][MAX_ZC-1:0]    s2_blk_q, s2_blk_d;
    logic                                err_q, err_d;

    logic                                s2_free, s1_adv, in_ready_w, in_fire;
    logic [2**SEL_W-1:0]                 sel_ok;
    logic [NUM_LANES-1:0]                lane_sel_ok, lane_shift_bad;
    logic                                in_zc_err;
    logic [MAX_ZC-1:0]                   in_mask, s1_mask;
    logic [NUM_LANES-1:0][ZC_W-1:0]      back_shift;
    logic [NUM_LANES-1:0][MAX_ZC-1:0]    rot;

    // Pipeline flow control; in_ready only looks at pipeline occupancy
    always_comb begin
        s2_free    = !s2_valid_q || bus.out_ready;
        s1_adv     = s1_valid_q && s2_free;
        in_ready_w = !s1_valid_q || s2_free;
        in_fire    = bus.in_valid && in_ready_w;
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_blocks = s2_blk_q;
    assign err_flag      = err_q;

    // Decode of the incoming transaction: legal selects, bad shifts, zc mask
    always_comb begin
        for (int k = 0; k < 2**SEL_W; k++) begin
            sel_ok[k] = (k < NUM_INPUTS);
        end
        in_zc_err = (bus.zc == '0) || (bus.zc > ZC_W'(MAX_ZC));
        for (int i = 0; i < MAX_ZC; i++) begin
            in_mask[i] = (ZC_W'(i) < bus.zc);
        end
        for (int l = 0; l < NUM_LANES; l++) begin
            lane_sel_ok[l]    = sel_ok[bus.select_lines[l]];
            lane_shift_bad[l] = ({1'b0, bus.shift_amounts[l]} >= bus.zc);
        end
    end

    // Stage 1 next state: mux the selected block (bits above zc cleared)
    always_comb begin
        s1_valid_d    = s1_valid_q;
        s1_blk_d      = s1_blk_q;
        s1_shift_d    = s1_shift_q;
        s1_zc_d       = s1_zc_q;
        s1_lane_err_d = s1_lane_err_q;
        s1_kill_d     = s1_kill_q;
        s1_zc_err_d   = s1_zc_err_q;
        if (in_fire) begin
            s1_valid_d  = 1'b1;
            s1_zc_d     = bus.zc;
            s1_zc_err_d = in_zc_err;
            for (int l = 0; l < NUM_LANES; l++) begin
                s1_blk_d[l]      = lane_sel_ok[l]
                                 ? (bus.parity_blocks[bus.select_lines[l]] & in_mask)
                                 : '0;
                s1_shift_d[l]    = bus.shift_amounts[l];
                s1_lane_err_d[l] = bus.lane_enable[l]
                                 && (!lane_sel_ok[l] || lane_shift_bad[l]);
                s1_kill_d[l]     = !bus.lane_enable[l] || !lane_sel_ok[l]
                                 || lane_shift_bad[l] || in_zc_err;
            end
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    // Rotation within zc: low part from >> shift, wrap part from << (zc - shift)
    always_comb begin
        for (int i = 0; i < MAX_ZC; i++) begin
            s1_mask[i] = (ZC_W'(i) < s1_zc_q);
        end
        for (int l = 0; l < NUM_LANES; l++) begin
            back_shift[l] = s1_zc_q - {1'b0, s1_shift_q[l]};
            rot[l] = ((s1_blk_q[l] >> s1_shift_q[l])
                     | (s1_blk_q[l] << back_shift[l])) & s1_mask;
            if (s1_kill_q[l]) begin
                rot[l] = '0;
            end
        end
    end

    // Stage 2 next state and sticky error (a set beats a coincident clear)
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_blk_d   = s2_blk_q;
        err_d      = err_q;
        if (s1_adv) begin
            s2_valid_d = 1'b1;
            s2_blk_d   = rot;
        end else if (bus.out_ready) begin
            s2_valid_d = 1'b0;
        end
        if (s1_adv && ((|s1_lane_err_q) || s1_zc_err_q)) begin
            err_d = 1'b1;
        end else if (err_clear) begin
            err_d = 1'b0;
        end
    end

    // State registers; reset drops everything in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            s1_blk_q      <= '0;
            s1_shift_q    <= '0;
            s1_zc_q       <= '0;
            s1_lane_err_q <= '0;
            s1_kill_q     <= '0;
            s1_zc_err_q   <= 1'b0;
            s2_valid_q    <= 1'b0;
            s2_blk_q      <= '0;
            err_q         <= 1'b0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_blk_q      <= s1_blk_d;
            s1_shift_q    <= s1_shift_d;
            s1_zc_q       <= s1_zc_d;
            s1_lane_err_q <= s1_lane_err_d;
            s1_kill_q     <= s1_kill_d;
            s1_zc_err_q   <= s1_zc_err_d;
            s2_valid_q    <= s2_valid_d;
            s2_blk_q      <= s2_blk_d;
            err_q         <= err_d;
        end
    end
endmodule

// File: tb/tb_ldpc_parity_select_rotate.sv
// Directed bench for ldpc_parity_select_rotate (3 inputs, 4 lanes).
module tb_ldpc_parity_select_rotate;
    import LDPC_pkg::*;

    localparam int NI  = 3;
    localparam int NL  = 4;
    localparam int MZ  = MAX_ZC;
    localparam int SW  = $clog2(MZ);
    localparam int ZW  = SW + 1;
    localparam int SLW = $clog2(NI);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err_clear = 1'b0;
    logic err_flag;
    int   cmp_cnt = 0;
    int   err_cnt = 0;

    logic [NL*MZ-1:0] exp_q[$];

    ldpc_parity_select_rotate_if #(.NUM_INPUTS(NI), .NUM_LANES(NL)) bus ();

    ldpc_parity_select_rotate #(.NUM_INPUTS(NI), .NUM_LANES(NL)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .err_clear (err_clear),
        .err_flag  (err_flag)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chkv(string tag, logic [MZ-1:0] obs, logic [MZ-1:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(string tag, logic obs, logic exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chki(string tag, int obs, int exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(int l, int sel, int sh, logic en);
        bus.select_lines[l]  = SLW'(sel);
        bus.shift_amounts[l] = SW'(sh);
        bus.lane_enable[l]   = en;
    endtask

    // zc=8 baseline: expected lanes D2, 0F, 03, A5
    task automatic cfg_basic();
        bus.zc = ZW'(8);
        bus.parity_blocks[0] = MZ'(16'hF0A5);
        bus.parity_blocks[1] = MZ'(8'h3C);
        bus.parity_blocks[2] = MZ'(8'h81);
        set_lane(0, 0, 1, 1'b1);
        set_lane(1, 1, 2, 1'b1);
        set_lane(2, 2, 7, 1'b1);
        set_lane(3, 0, 0, 1'b1);
    endtask

    // One transaction into an idle pipeline, out_ready high
    task automatic run_txn(string tag);
        chk1({tag, "_in_ready"}, bus.in_ready, 1'b1);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk1({tag, "_lat1"}, bus.out_valid, 1'b0);
        tick();
        chk1({tag, "_lat2"}, bus.out_valid, 1'b1);
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
    endtask

    // Stream transaction k: zc=5+k, lane0 one-hot bit0 shifted by k,
    // lane1 all-ones, lane2 bits{0,1} shifted by 1, lane3 disabled
    function automatic logic [NL*MZ-1:0] expv(int k);
        int zc;
        logic [MZ-1:0] l0, l1, l2;
        zc = 5 + k;
        l0 = MZ'(1) << ((zc - k) % zc);
        l1 = (MZ'(1) << zc) - MZ'(1);
        l2 = MZ'(1) | (MZ'(1) << (zc - 1));
        return {MZ'(0), l2, l1, l0};
    endfunction

    initial begin
        logic [NL*MZ-1:0] e;
        logic [3:0] pat;
        int sent, recv, cyc;
        logic in_f, out_f;

        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.zc = '0;
        bus.parity_blocks = '0;
        bus.select_lines = '0;
        bus.shift_amounts = '0;
        bus.lane_enable = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_out_valid", bus.out_valid, 1'b0);
        chk1("rst_err_flag", err_flag, 1'b0);
        for (int l = 0; l < NL; l++) chkv("rst_out_blocks", bus.out_blocks[l], '0);
        rst = 1'b0;
        chk1("rst_in_ready", bus.in_ready, 1'b1);

        // Basic select/rotate at zc=8
        cfg_basic();
        run_txn("t1");
        chkv("t1_lane0", bus.out_blocks[0], MZ'(8'hD2));
        chkv("t1_lane1", bus.out_blocks[1], MZ'(8'h0F));
        chkv("t1_lane2", bus.out_blocks[2], MZ'(8'h03));
        chkv("t1_lane3", bus.out_blocks[3], MZ'(8'hA5));
        chk1("t1_err", err_flag, 1'b0);

        // zc=384 wrap and identity
        bus.zc = ZW'(384);
        bus.parity_blocks[0] = MZ'(1);
        bus.parity_blocks[1] = {12{32'hDEADBEEF}};
        bus.parity_blocks[2] = MZ'(1) << 383;
        set_lane(0, 0, 383, 1'b1);
        set_lane(1, 1, 0, 1'b1);
        set_lane(2, 2, 1, 1'b1);
        set_lane(3, 2, 5, 1'b0);
        run_txn("t384");
        chkv("t384_lane0", bus.out_blocks[0], MZ'(2));
        chkv("t384_lane1", bus.out_blocks[1], {12{32'hDEADBEEF}});
        chkv("t384_lane2", bus.out_blocks[2], MZ'(1) << 382);
        chkv("t384_lane3", bus.out_blocks[3], '0);
        chk1("t384_err", err_flag, 1'b0);

        // Stream of 10 with out_ready pattern 1,0,0,1
        bus.parity_blocks[0] = MZ'(1);
        bus.parity_blocks[1] = '1;
        bus.parity_blocks[2] = MZ'(3);
        pat = 4'b1001;
        sent = 0;
        recv = 0;
        cyc = 0;
        tick();
        while (recv < 10 && cyc < 80) begin
            bus.out_ready = pat[cyc % 4];
            if (sent < 10) begin
                bus.in_valid = 1'b1;
                bus.zc = ZW'(5 + sent);
                set_lane(0, 0, sent, 1'b1);
                set_lane(1, 1, sent % 3, 1'b1);
                set_lane(2, 2, 1, 1'b1);
                set_lane(3, 0, 0, 1'b0);
            end else begin
                bus.in_valid = 1'b0;
            end
            #3;
            chk1("strm_in_ready", bus.in_ready,
                 !(((sent - recv) == 2) && !bus.out_ready));
            if (bus.out_valid) begin
                chk1("strm_q_nonempty", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q[0];
                    for (int l = 0; l < NL; l++)
                        chkv($sformatf("strm_txn%0d_lane%0d", recv, l),
                             bus.out_blocks[l], e[l*MZ +: MZ]);
                end
            end
            in_f  = bus.in_valid && bus.in_ready;
            out_f = bus.out_valid && bus.out_ready;
            if (out_f && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                recv++;
            end
            if (in_f) begin
                exp_q.push_back(expv(sent));
                sent++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        chki("strm_count", recv, 10);
        tick();

        // Lane 3 select out of range
        cfg_basic();
        set_lane(3, 3, 0, 1'b1);
        run_txn("esel");
        chkv("esel_lane3", bus.out_blocks[3], '0);
        chkv("esel_lane0", bus.out_blocks[0], MZ'(8'hD2));
        chk1("esel_err", err_flag, 1'b1);
        set_lane(3, 0, 0, 1'b1);
        run_txn("sticky");
        chkv("sticky_lane3", bus.out_blocks[3], MZ'(8'hA5));
        chk1("sticky_err", err_flag, 1'b1);
        pulse_clear();
        chk1("clear_err", err_flag, 1'b0);

        // Lane 3 shift >= zc, with clear held across the setting edge
        set_lane(3, 0, 9, 1'b1);
        err_clear = 1'b1;
        run_txn("eshift");
        err_clear = 1'b0;
        chkv("eshift_lane3", bus.out_blocks[3], '0);
        chk1("eshift_set_wins", err_flag, 1'b1);
        pulse_clear();
        chk1("eshift_clear", err_flag, 1'b0);

        // Same conditions on a disabled lane raise nothing
        set_lane(3, 3, 9, 1'b0);
        run_txn("dis");
        chkv("dis_lane3", bus.out_blocks[3], '0);
        chkv("dis_lane1", bus.out_blocks[1], MZ'(8'h0F));
        chk1("dis_err", err_flag, 1'b0);

        // zc = 0 and zc > MAX_ZC
        cfg_basic();
        bus.zc = '0;
        run_txn("zc0");
        for (int l = 0; l < NL; l++) chkv("zc0_lane", bus.out_blocks[l], '0);
        chk1("zc0_err", err_flag, 1'b1);
        pulse_clear();
        bus.zc = ZW'(385);
        set_lane(0, 0, 0, 1'b1);
        run_txn("zcbig");
        for (int l = 0; l < NL; l++) chkv("zcbig_lane", bus.out_blocks[l], '0);
        chk1("zcbig_err", err_flag, 1'b1);

        // Reset with both stages full
        cfg_basic();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        tick();
        tick();
        bus.in_valid = 1'b0;
        chk1("full_out_valid", bus.out_valid, 1'b1);
        chk1("full_in_ready", bus.in_ready, 1'b0);
        chk1("full_err", err_flag, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk1("arst_out_valid", bus.out_valid, 1'b0);
        chk1("arst_err", err_flag, 1'b0);
        for (int l = 0; l < NL; l++) chkv("arst_out_blocks", bus.out_blocks[l], '0);
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        run_txn("post_rst");
        chkv("post_rst_lane0", bus.out_blocks[0], MZ'(8'hD2));
        chk1("post_rst_err", err_flag, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
